muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core. It is the successor to the fixed single-cycle HI/LO path. It sits beside the execute-stage ALU: the core issues an op with a start strobe and stalls on busy_o, and mfhi/mflo read hi_o/lo_o. It adds signed/unsigned iterative divide, flush cancellation and defined divide-by-zero results.

---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_ACC_EN.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + {{(W2-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [W2-1:0]    acc_r, acc_step_s, prod_s, fix_s, hilo_s;
  logic [WIDTH-1:0] opb_r, araw_r, hi_r, lo_r;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, quo_s, rem_s;
  logic [2:0]       op_r;
  logic             qsign_r, rsign_r, bzero_r, done_r;
  logic             is_signed_s, is_calc_op_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;

  // Issue-time decode and operand magnitudes
  always_comb begin
    is_signed_s = (op_i == OP_MULT) || (op_i == OP_DIV) ||
                  (op_i == OP_MADD) || (op_i == OP_MSUB);
`ifdef MULDIV_ACC_EN
    is_calc_op_s = (op_i != OP_MTHI) && (op_i != OP_MTLO);
`else
    is_calc_op_s = (op_i[2] == 1'b0);
`endif
    a_abs_s = (is_signed_s && a_i[WIDTH-1]) ? neg_w(a_i) : a_i;
    b_abs_s = (is_signed_s && b_i[WIDTH-1]) ? neg_w(b_i) : b_i;
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[W2-1:WIDTH]} + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    div_sh_s   = acc_r[W2-1:WIDTH-1];
    // Remainder stays below the divisor, so bit WIDTH of the difference is its sign
    div_diff_s = div_sh_s - {1'b0, opb_r};
    if ((op_r == OP_DIV) || (op_r == OP_DIVU)) begin
      if (!div_diff_s[WIDTH]) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and final HI/LO value written at the end of FIX
  always_comb begin
    prod_s = qsign_r ? neg_2w(acc_r) : acc_r;
    quo_s  = qsign_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s  = rsign_r ? neg_w(acc_r[W2-1:WIDTH]) : acc_r[W2-1:WIDTH];
    hilo_s = {hi_r, lo_r};
    fix_s  = hilo_s;
    case (op_r)
      OP_MULT, OP_MULTU: fix_s = prod_s;
      OP_DIV, OP_DIVU: begin
        if (bzero_r) begin
          fix_s = {araw_r, {WIDTH{1'b1}}};
        end else begin
          fix_s = {rem_s, quo_s};
        end
      end
`ifdef MULDIV_ACC_EN
      OP_MADD: fix_s = hilo_s + prod_s;
      OP_MSUB: fix_s = hilo_s - prod_s;
`endif
      default: fix_s = hilo_s;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i && !cancel_i && is_calc_op_s) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cancel_i) begin
          state_s = IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {W2{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      araw_r  <= {WIDTH{1'b0}};
      op_r    <= 3'b000;
      qsign_r <= 1'b0;
      rsign_r <= 1'b0;
      bzero_r <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i && !cancel_i) begin
            if (op_i == OP_MTHI) begin
              hi_r <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo_r <= a_i;
            end else if (is_calc_op_s) begin
              op_r    <= op_i;
              acc_r   <= {{WIDTH{1'b0}}, a_abs_s};
              opb_r   <= b_abs_s;
              araw_r  <= a_i;
              bzero_r <= (b_i == {WIDTH{1'b0}});
              qsign_r <= is_signed_s & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              rsign_r <= is_signed_s & a_i[WIDTH-1];
              cnt_r   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          if (!cancel_i) begin
            acc_r <= acc_step_s;
            if (cnt_r != {CNT_W{1'b0}}) begin
              cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        FIX: begin
          if (!cancel_i) begin
            hi_r   <= fix_s[W2-1:WIDTH];
            lo_r   <= fix_s[WIDTH-1:0];
            done_r <= 1'b1;
          end
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign busy_o = (state_r != IDLE);
  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, results checked by a monitor on done_o.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         cancel_i = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errs = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] mon_exp;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done_o=1, expected no pending result");
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result_hilo", {hi_o, lo_o}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    int bcnt;
    sb_q.push_back({eh, el});
    issue(op, a, b);
    lat = 1;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (done_o) break;
      if (busy_o) bcnt++;
      lat++;
    end
    chk({name, "_latency"}, lat, W + 2);
    chk({name, "_busy_cycles"}, bcnt, W + 1);
    chk({name, "_busy_at_done"}, busy_o, 1'b0);
    @(negedge clk);
    chk({name, "_done_width"}, done_o, 1'b0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
  endtask

  initial begin
    int dcnt;
    int bhi;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);

    run_op("mult_neg2x3", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("multu_max_2", 3'b001, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_m9_0", 3'b010, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
    run_op("divu_5_0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

    // Flush at cycle 10 of a MULTU: no result, HI/LO untouched
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1 cancel_i = 1'b1;
    @(posedge clk);
    #1 cancel_i = 1'b0;
    chk("cancel_busy", busy_o, 1'b0);
    chk("cancel_hi", hi_o, 32'd5);
    chk("cancel_lo", lo_o, 32'hFFFFFFFF);
    count_done(40, dcnt);
    chk("cancel_no_done", dcnt, 0);
    run_op("multu_reissue", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // Cancel in IDLE suppresses MTHI
    @(posedge clk); #1;
    start_i = 1'b1; cancel_i = 1'b1; op_i = 3'b100; a_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    chk("idle_cancel_hi", hi_o, 32'hFFFFFFFE);
    chk("idle_cancel_busy", busy_o, 1'b0);

    // Back-to-back MTHI / MTLO
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b100; a_i = 32'h12345678;
    @(posedge clk); #1;
    op_i = 3'b101; a_i = 32'h9ABCDEF0;
    chk("mthi_hi", hi_o, 32'h12345678);
    chk("mthi_busy", busy_o, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi_o, 32'h12345678);
    chk("mtlo_busy", busy_o, 1'b0);

    // Start while busy is ignored: exactly one result
    sb_q.push_back({32'h0, 32'd6});
    issue(3'b000, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    #1 start_i = 1'b1; op_i = 3'b000; a_i = 32'd5; b_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0;
    count_done(70, dcnt);
    chk("busy_start_one_done", dcnt, 1);

    // Reset during CALC clears HI/LO and aborts
    issue(3'b000, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_calc_hi", hi_o, 32'h0);
    chk("rst_calc_lo", lo_o, 32'h0);
    chk("rst_calc_busy", busy_o, 1'b0);
    count_done(40, dcnt);
    chk("rst_calc_no_done", dcnt, 0);

    // Accumulate ops
    issue(3'b100, 32'h0, 32'h0);
    issue(3'b101, 32'd10, 32'h0);
`ifdef MULDIV_ACC_EN
    run_op("msub_3x4", 3'b111, 32'd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("madd_5xm3", 3'b110, 32'd5, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEF);
`else
    issue(3'b111, 32'd3, 32'd4);
    bhi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o) bhi++;
    end
    chk("msub_off_busy", bhi, 0);
    chk("msub_off_hi", hi_o, 32'h0);
    chk("msub_off_lo", lo_o, 32'd10);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
